// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO driver: register map, status bits,
// FSM states and the bus-access descriptor each state drives.
package uart_mmio_pkg;

    localparam logic [31:0] OFFSET_BAUD    = 32'd0;
    localparam logic [31:0] OFFSET_GETCHAR = 32'd4;
    localparam logic [31:0] OFFSET_SETCHAR = 32'd8;
    localparam logic [31:0] OFFSET_STATUS  = 32'd12;

    localparam int STATUS_TX_DONE = 0;
    localparam int STATUS_RX_DONE = 1;

    typedef enum logic [2:0] {
        WAIT,
        INIT,
        POLL,
        WR_BAUD,
        RD_CHAR,
        WR_CHAR
    } state_e;

    typedef struct packed {
        logic        enable;
        logic        read;
        logic [31:0] address;
        logic [31:0] store;
    } mmio_access_t;

    // Bus access issued while the FSM sits in a given state; all-zero when idle.
    function automatic mmio_access_t access_for(
        input state_e      state,
        input logic [31:0] base,
        input logic [31:0] reset_baud,
        input logic [31:0] baud,
        input logic [7:0]  tx_head
    );
        mmio_access_t acc;
        acc = '0;
        case (state)
            INIT: begin
                acc.enable  = 1'b1;
                acc.address = base + OFFSET_BAUD;
                acc.store   = reset_baud;
            end
            POLL: begin
                acc.enable  = 1'b1;
                acc.read    = 1'b1;
                acc.address = base + OFFSET_STATUS;
            end
            WR_BAUD: begin
                acc.enable  = 1'b1;
                acc.address = base + OFFSET_BAUD;
                acc.store   = baud;
            end
            RD_CHAR: begin
                acc.enable  = 1'b1;
                acc.read    = 1'b1;
                acc.address = base + OFFSET_GETCHAR;
            end
            WR_CHAR: begin
                acc.enable  = 1'b1;
                acc.address = base + OFFSET_SETCHAR;
                acc.store   = {24'h0, tx_head};
            end
            default: acc = '0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO holding characters waiting to be written to the UART.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents are only meaningful between the pointers.
    // NOTE: the data array has no reset -- the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_mmio_driver.sv
// Drives a memory-mapped UART: programs the baud divisor, polls status,
// fetches received bytes and writes queued bytes, one bus access per cycle.
module uart_mmio_driver
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] RESET_BAUD = 32'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] data_address,
    output logic [31:0] data_store,
    input  logic [31:0] data_fetch,
    output logic        data_read,
    output logic        data_enable,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] baud_div,
    input  logic        baud_load,
    output logic        busy
);

    state_e       state;
    state_e       next_state;
    mmio_access_t access_q;

    logic        tx_free;
    logic        baud_pending;
    logic [31:0] baud_value;
    logic [31:0] next_baud;

    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    // Only the low byte of a fetch matters; status and getchar upper bits are ignored.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^data_fetch[31:8];

    assign fifo_push = tx_valid && !fifo_full;
    assign fifo_pop  = (state == WR_CHAR);
    assign tx_ready  = !fifo_full;
    assign busy      = (state != POLL) || !fifo_empty || baud_pending;

    // A load arriving on the edge that enters WR_BAUD is the value written.
    assign next_baud = baud_load ? baud_div : baud_value;

    assign data_enable  = access_q.enable;
    assign data_read    = access_q.read;
    assign data_address = access_q.address;
    assign data_store   = access_q.store;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .wr_data(tx_byte),
        .pop    (fifo_pop),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Next-state selection; POLL decides from the status word fetched this cycle.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            WAIT: next_state = INIT;
            INIT: next_state = POLL;
            POLL: begin
                if (baud_pending) begin
                    next_state = WR_BAUD;
                end else if (data_fetch[STATUS_RX_DONE] && !rx_valid) begin
                    next_state = RD_CHAR;
                end else if (!fifo_empty && (tx_free || data_fetch[STATUS_TX_DONE])) begin
                    next_state = WR_CHAR;
                end else begin
                    next_state = POLL;
                end
            end
            WR_BAUD, RD_CHAR, WR_CHAR: next_state = POLL;
            default: next_state = WAIT;
        endcase
    end

    // FSM state, registered bus access and the flags the states set and clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT;
            access_q     <= '0;
            tx_free      <= 1'b0;
            baud_pending <= 1'b0;
            baud_value   <= '0;
            rx_valid     <= 1'b0;
            rx_byte      <= 8'h00;
        end else begin
            state <= next_state;
            // NOTE: the access is registered from next_state so the bus pins come straight off flops.
            access_q <= access_for(next_state, BASE_ADDR, RESET_BAUD, next_baud, fifo_head);

            if (baud_load) begin
                baud_pending <= 1'b1;
                baud_value   <= baud_div;
            end else if (state == WR_BAUD) begin
                baud_pending <= 1'b0;
            end

            if (state == INIT) begin
                tx_free <= 1'b1;
            end else if (state == POLL && data_fetch[STATUS_TX_DONE]) begin
                tx_free <= 1'b1;
            end else if (state == WR_CHAR) begin
                tx_free <= 1'b0;
            end

            if (state == RD_CHAR) begin
                rx_byte  <= data_fetch[7:0];
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio_driver.sv
// Self-checking bench for uart_mmio_driver: a transaction-level model predicts
// every bus access, the TX byte stream, the RX handshake, tx_ready and busy.
module tb_uart_mmio_driver;

    localparam logic [31:0] BASE  = 32'h1000_0100;
    localparam int          DEPTH = 4;

    localparam int K_NONE = 0;
    localparam int K_BAUD = 1;
    localparam int K_GET  = 2;
    localparam int K_SET  = 3;
    localparam int K_POLL = 4;
    localparam int K_BAD  = 5;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_address;
    logic [31:0] data_store;
    logic [31:0] data_fetch;
    logic        data_read;
    logic        data_enable;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] baud_div;
    logic        baud_load;
    logic        busy;

    logic [31:0] status_reg;
    logic [31:0] getchar_reg;
    logic [31:0] junk;

    // Reference model state
    logic [7:0]  q[$];
    int          exp_kind;
    bit          exp_init;
    bit          pending_m;
    logic [31:0] val_m;
    bit          rx_valid_m;
    logic [7:0]  rx_byte_m;
    bit          tx_free_m;
    bit          last_accept;

    int          n_checks;
    int          n_pass;
    int          set_seen;
    int          get_seen;
    int          baud_seen;
    logic [31:0] last_baud;
    int          acc_log[$];

    uart_mmio_driver #(
        .BASE_ADDR (BASE),
        .RESET_BAUD(32'd434),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_address(data_address),
        .data_store  (data_store),
        .data_fetch  (data_fetch),
        .data_read   (data_read),
        .data_enable (data_enable),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .baud_div    (baud_div),
        .baud_load   (baud_load),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART register file seen by the driver: combinational read data.
    always_comb begin
        data_fetch = junk;
        if (data_enable && data_read) begin
            if (data_address == BASE + 32'd12) data_fetch = status_reg;
            else if (data_address == BASE + 32'd4) data_fetch = getchar_reg;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bus_kind();
        if (!data_enable) return K_NONE;
        if (!data_read && data_address == BASE)           return K_BAUD;
        if ( data_read && data_address == BASE + 32'd4)   return K_GET;
        if (!data_read && data_address == BASE + 32'd8)   return K_SET;
        if ( data_read && data_address == BASE + 32'd12)  return K_POLL;
        return K_BAD;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_kind   = K_NONE;
        exp_init   = 1'b0;
        pending_m  = 1'b0;
        val_m      = '0;
        rx_valid_m = 1'b0;
        rx_byte_m  = 8'h00;
        tx_free_m  = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs of the cycle just ended.
    task automatic model_update();
        int  nk;
        bit  ninit;
        bit  accept;
        nk    = K_POLL;
        ninit = 1'b0;
        if (exp_kind == K_NONE) begin
            nk    = K_BAUD;
            ninit = 1'b1;
        end else if (exp_kind == K_POLL) begin
            if (pending_m)                                        nk = K_BAUD;
            else if (status_reg[1] && !rx_valid_m)                nk = K_GET;
            else if (q.size() > 0 && (tx_free_m || status_reg[0])) nk = K_SET;
            else                                                  nk = K_POLL;
        end

        if (exp_kind == K_BAUD && exp_init)       tx_free_m = 1'b1;
        if (exp_kind == K_POLL && status_reg[0])  tx_free_m = 1'b1;
        if (exp_kind == K_SET)                    tx_free_m = 1'b0;

        if (exp_kind == K_BAUD && !exp_init) pending_m = 1'b0;
        if (baud_load) begin
            pending_m = 1'b1;
            val_m     = baud_div;
        end

        accept = tx_valid && (q.size() < DEPTH);
        if (exp_kind == K_SET && q.size() > 0) void'(q.pop_front());
        if (accept) q.push_back(tx_byte);
        last_accept = accept;

        if (exp_kind == K_GET) begin
            rx_valid_m = 1'b1;
            rx_byte_m  = getchar_reg[7:0];
        end else if (rx_valid_m && rx_ready) begin
            rx_valid_m = 1'b0;
        end

        exp_kind = nk;
        exp_init = ninit;
    endtask

    task automatic check_outputs();
        int k;
        k = bus_kind();
        if (!data_enable) begin
            check("idle_address", data_address, 32'h0);
            check("idle_store", data_store, 32'h0);
            check("idle_read", {31'h0, data_read}, 32'h0);
        end
        check("access_kind", k, exp_kind);
        if (exp_kind == K_BAUD)
            check("baud_value", data_store, exp_init ? 32'd434 : val_m);
        if (exp_kind == K_SET && q.size() > 0)
            check("setchar_value", data_store, {24'h0, q[0]});
        check("tx_ready", {31'h0, tx_ready}, {31'h0, q.size() < DEPTH});
        check("rx_valid", {31'h0, rx_valid}, {31'h0, rx_valid_m});
        check("rx_byte", {24'h0, rx_byte}, {24'h0, rx_byte_m});
        check("busy", {31'h0, busy},
              {31'h0, (exp_kind != K_POLL) || (q.size() != 0) || pending_m});
        if (k == K_SET) set_seen++;
        if (k == K_GET) get_seen++;
        if (k == K_BAUD) begin
            baud_seen++;
            last_baud = data_store;
        end
        if (k != K_NONE && k != K_POLL) acc_log.push_back(k);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_enable"}, {31'h0, data_enable}, 32'h0);
        check({tag, "_read"}, {31'h0, data_read}, 32'h0);
        check({tag, "_address"}, data_address, 32'h0);
        check({tag, "_store"}, data_store, 32'h0);
        check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h1);
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
        check({tag, "_rx_byte"}, {24'h0, rx_byte}, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
        check_outputs();
        junk = $urandom();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        tx_byte  = b;
        tx_valid = 1'b1;
        do begin
            tick();
            guard++;
        end while (!last_accept && guard < 64);
        tx_valid = 1'b0;
        check("push_accepted", {31'h0, last_accept}, 32'h1);
    endtask

    task automatic clear_stats();
        set_seen  = 0;
        get_seen  = 0;
        baud_seen = 0;
        last_baud = '0;
        acc_log.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        tx_byte     = 8'h00;
        tx_valid    = 1'b0;
        rx_ready    = 1'b0;
        baud_div    = '0;
        baud_load   = 1'b0;
        status_reg  = '0;
        getchar_reg = '0;
        junk        = '0;
        last_accept = 1'b0;
        model_reset();
        clear_stats();

        // Reset values, then the WAIT -> INIT -> polling start-up sequence.
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        run(6);
        check("init_baud_count", baud_seen, 1);
        check("init_baud_value", last_baud, 32'd434);

        // Two bytes with transmit_done stuck low: the first goes, the second waits.
        clear_stats();
        push_byte(8'h41);
        push_byte(8'h42);
        run(10);
        check("first_byte_only", set_seen, 1);
        status_reg = 32'h1;
        run(4);
        check("second_byte_after_done", set_seen, 2);
        status_reg = 32'h0;
        run(2);

        // Received byte held until the consumer takes it.
        clear_stats();
        status_reg  = 32'h2;
        getchar_reg = 32'h5A;
        rx_ready    = 1'b0;
        run(8);
        check("rx_held_valid", {31'h0, rx_valid}, 32'h1);
        check("rx_held_byte", {24'h0, rx_byte}, 32'h5A);
        check("single_getchar", get_seen, 1);
        rx_ready   = 1'b1;
        status_reg = 32'h0;
        tick();
        rx_ready = 1'b0;
        run(3);
        check("rx_released", {31'h0, rx_valid}, 32'h0);

        // Fill the FIFO while transmit_done is low, then drain in order.
        push_byte(8'h30);
        run(6);
        clear_stats();
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        push_byte(8'hA4);
        check("full_after_fourth", {31'h0, tx_ready}, 32'h0);
        tx_byte  = 8'hA5;
        tx_valid = 1'b1;
        run(5);
        check("full_blocks_fifth", {31'h0, tx_ready}, 32'h0);
        status_reg = 32'h1;
        begin
            int guard;
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!last_accept && guard < 64);
            check("fifth_accepted", {31'h0, last_accept}, 32'h1);
        end
        tx_valid = 1'b0;
        run(12);
        check("drained_count", set_seen, 5);
        status_reg = 32'h0;
        run(2);

        // Two baud loads before the write, with a receive pending as well.
        clear_stats();
        baud_div  = 32'd868;
        baud_load = 1'b1;
        tick();
        baud_div    = 32'd54;
        status_reg  = 32'h2;
        getchar_reg = 32'h77;
        rx_ready    = 1'b1;
        tick();
        baud_load = 1'b0;
        run(6);
        status_reg = 32'h0;
        run(2);
        check("baud_single_write", baud_seen, 1);
        check("baud_last_wins", last_baud, 32'd54);
        check("baud_before_getchar", acc_log.size() >= 2 ? acc_log[0] * 8 + acc_log[1] : 0,
              K_BAUD * 8 + K_GET);
        rx_ready = 1'b0;

        // Reset in the middle of activity discards queued bytes and the held rx byte.
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        push_byte(8'hC4);
        status_reg  = 32'h2;
        getchar_reg = 32'hA5;
        run(4);
        check("rx_before_reset", {31'h0, rx_valid}, 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("midrst");
        run(2);
        clear_stats();
        status_reg = 32'h1;
        rst_n      = 1'b1;
        run(10);
        check("no_stale_bytes", set_seen, 0);
        check("reinit_baud_count", baud_seen, 1);
        check("reinit_baud_value", last_baud, 32'd434);

        // Randomized traffic against the model, with rare resets.
        for (int i = 0; i < 3000; i++) begin
            status_reg  = $urandom();
            getchar_reg = $urandom();
            tx_byte     = 8'($urandom());
            tx_valid    = ($urandom_range(0, 1) == 1);
            rx_ready    = ($urandom_range(0, 3) == 0);
            baud_load   = ($urandom_range(0, 15) == 0);
            baud_div    = $urandom();
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_driver.md
UART_MMIO_DRIVER -- requirements
Module: uart_mmio_driver

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: word-aligned base of the UART register block (offsets 0 baud, 4 getchar, 8 setchar, 12 status).
REQ-002 SHALL have parameter RESET_BAUD, default 32'd434: divisor written to the baud register after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: TX byte FIFO depth, power of two, >=2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_address  output  32  MMIO address.
REQ-007 data_store  output  32  MMIO write data.
REQ-008 data_fetch  input  32  MMIO read data, valid combinationally in the access cycle.
REQ-009 data_read  output  1  1 = read, 0 = write; meaningful only with data_enable.
REQ-010 data_enable  output  1  access strobe, one cycle per access.
REQ-011 tx_byte / tx_valid / tx_ready  input 8 / input 1 / output 1  byte-to-send handshake.
REQ-012 rx_byte / rx_valid / rx_ready  output 8 / output 1 / input 1  received-byte handshake.
REQ-013 baud_div / baud_load  input 32 / input 1  new divisor and one-cycle load pulse.
REQ-014 busy  output  1  high while any access, queued byte or pending baud write is outstanding.

Function
REQ-015 SHALL issue at most one MMIO access per cycle; data_address, data_store and data_read SHALL be 0 whenever data_enable is 0.
REQ-016 SHALL implement FSM states WAIT, INIT, POLL, WR_BAUD, RD_CHAR, WR_CHAR; exactly one access per non-WAIT state; every access state except POLL returns to POLL.
REQ-017 WAIT: no access; unconditionally goes to INIT on the next cycle.
REQ-018 INIT: write RESET_BAUD to BASE+0; set tx_free; go to POLL.
REQ-019 POLL: read BASE+12; choose the next state from live data_fetch in the same cycle, priority WR_BAUD (baud pending) > RD_CHAR (bit1 = 1 and rx_valid = 0) > WR_CHAR (FIFO non-empty and (tx_free or bit0 = 1)) > POLL.
REQ-020 A POLL read with bit0 = 1 SHALL set tx_free; only WR_CHAR SHALL clear it.
REQ-021 WR_BAUD: write the pending divisor to BASE+0 and clear pending; a baud_load in the same cycle SHALL leave the new value pending; the last baud_load before the write wins.
REQ-022 RD_CHAR: read BASE+4; capture data_fetch[7:0] into rx_byte; set rx_valid.
REQ-023 rx_valid SHALL hold with rx_byte stable until the cycle rx_valid and rx_ready are both high; no RD_CHAR while rx_valid = 1.
REQ-024 WR_CHAR: write {24'h0, FIFO head} to BASE+8; pop FIFO; clear tx_free.
REQ-025 tx_ready SHALL equal FIFO not-full; push on tx_valid and tx_ready; FIFO order strict; pointers wrap modulo FIFO_DEPTH with an extra bit for full/empty.
REQ-026 With the FSM in POLL, tx_free = 1, nothing else pending and the FIFO empty, a byte accepted at edge t SHALL be written by WR_CHAR within 2 cycles (at t+1 or t+2).
REQ-027 busy SHALL equal (state != POLL) or FIFO non-empty or baud pending.

Reset
REQ-028 On rst_n low: state WAIT; FIFO empty; tx_free 0; baud pending 0; rx_valid 0; rx_byte 8'h00; data_enable, data_read 0; data_address, data_store 32'h0; tx_ready 1; busy 1.
REQ-029 Reset mid-operation SHALL discard FIFO contents, pending baud and any held rx byte; no access is issued until INIT.

Structure
REQ-030 Shared package uart_mmio_pkg SHALL hold the register offset constants, status bit indices (0 transmit_done, 1 receive_done) and the FSM state enum.
REQ-031 The TX FIFO SHALL be a sub-module uart_tx_fifo (parameter DEPTH, width 8).

Verification
REQ-032 Reset release -> WAIT for 1 cycle, then a write of 434 to BASE+0, then continuous reads of BASE+12.
REQ-033 Push 8'h41, 8'h42 with status bit0 stuck 0 -> 8'h41 written to BASE+8; 8'h42 held until a poll returns bit0 = 1, then written.
REQ-034 Poll returns 32'h2, getchar returns 32'h5A -> read of BASE+4; rx_byte = 8'h5A, rx_valid held while rx_ready = 0; no further getchar read until the handshake.
REQ-035 Push 5 bytes with FIFO_DEPTH = 4 while bit0 = 0 -> tx_ready low after the 4th byte; bytes sent in order once bit0 = 1.
REQ-036 baud_load 32'd868, then 32'd54 before the write, with rx also pending -> single write of 54 to BASE+0 before the getchar read.
REQ-037 Assert rst_n low with 3 bytes queued and rx_valid = 1 -> all outputs at reset values; after release only the INIT sequence, no stale bytes written.
